// File: rtl/vmicro16_apb_master_if.sv
// APB3 bus bundle between the vmicro16 APB initiator and the interconnect.
// Ports: M_PADDR/M_PWRITE/M_PSELx/M_PENABLE/M_PWDATA driven by the master,
//        M_PRDATA/M_PREADY driven by the slave side.
interface vmicro16_apb_master_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] M_PADDR;
  logic                  M_PWRITE;
  logic                  M_PSELx;
  logic                  M_PENABLE;
  logic [DATA_WIDTH-1:0] M_PWDATA;
  logic [DATA_WIDTH-1:0] M_PRDATA;
  logic                  M_PREADY;

  modport master (
    output M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
    input  M_PRDATA, M_PREADY
  );

  modport slave (
    input  M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
    output M_PRDATA, M_PREADY
  );
endinterface

// File: rtl/vmicro16_apb_master.sv
// APB3 initiator: turns one outstanding core load/store into an APB SETUP/ACCESS
// transfer and returns a one-cycle core_ack (latency 3 + wait states).
// Ports: clk/reset (sync, active-high); core_req/we/addr/wdata in;
//        core_ack/err/rdata/busy out; apb = APB master modport (all outputs registered).
// Optional macro VMICRO16_APB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES stalled
// cycles and complete with core_err=1; without it ACCESS waits forever, core_err=0.
module vmicro16_apb_master #(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_ack,
  output logic                  core_err,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_busy,
  vmicro16_apb_master_if.master apb
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  // Elaboration-time guard on the timeout length.
  generate
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("vmicro16_apb_master: TIMEOUT_CYCLES must be >= 1");
    end
  endgenerate

  state_t                state_q,   state_d;
  logic                  psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q,   paddr_d;
  logic                  pwrite_q,  pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;
  logic                  ack_q,     ack_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic                  timeout;

`ifdef VMICRO16_APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Held at zero outside ACCESS, so every ACCESS phase starts counting from 0.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != ST_ACCESS) begin
      cnt_d = '0;
    end else if (!apb.M_PREADY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // cnt_q holds the number of already-stalled ACCESS cycles; a stall on the
  // TIMEOUT_CYCLES-th cycle is the abort point. PREADY on it still wins.
  assign timeout = (state_q == ST_ACCESS) && !apb.M_PREADY &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err_d   = timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign core_err = err_q;
`else
  assign timeout  = 1'b0;
  assign core_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (core_req) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.M_PREADY) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          if (!pwrite_q) begin
            rdata_d = apb.M_PRDATA;
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          rdata_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // APB outputs are registered copies of what the next state requires.
    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);

    if (state_d == ST_IDLE) begin
      paddr_d  = '0;
      pwrite_d = 1'b0;
      pwdata_d = '0;
    end else if (state_q == ST_IDLE) begin
      // Request accepted this cycle: capture the core fields once.
      paddr_d  = core_addr;
      pwrite_d = core_we;
      pwdata_d = core_wdata;
    end else begin
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign apb.M_PADDR   = paddr_q;
  assign apb.M_PWRITE  = pwrite_q;
  assign apb.M_PSELx   = psel_q;
  assign apb.M_PENABLE = penable_q;
  assign apb.M_PWDATA  = pwdata_q;

  assign core_ack   = ack_q;
  assign core_rdata = rdata_q;
  assign core_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vmicro16_apb_master.sv
// Bench for vmicro16_apb_master: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_vmicro16_apb_master;
  localparam int AW     = 20;
  localparam int DW     = 16;
  localparam int TO_CYC = 4;
`ifdef VMICRO16_APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          core_req = 1'b0;
  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_ack;
  logic          core_err;
  logic [DW-1:0] core_rdata;
  logic          core_busy;

  vmicro16_apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_if_i ();

  vmicro16_apb_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_err(core_err),
    .core_rdata(core_rdata), .core_busy(core_busy),
    .apb(apb_if_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_ack = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, tracked by its age in cycles
  // since acceptance (1 = SETUP, >=2 = ACCESS cycle number age-1).
  bit            m_act = 0;
  int            m_age = 0;
  logic          m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ack = 0;
  logic          m_err = 0;

  always @(posedge clk) begin
    m_ack = 1'b0;
    m_err = 1'b0;
    if (reset) begin
      m_act = 0; m_age = 0; m_rdata = '0;
    end else if (!m_act) begin
      if (core_req) begin
        m_act = 1; m_age = 1;
        m_we = core_we; m_addr = core_addr; m_wdata = core_wdata;
      end
    end else if (m_age == 1) begin
      m_age = 2;
    end else if (apb_if_i.M_PREADY) begin
      m_act = 0; m_ack = 1'b1;
      if (!m_we) m_rdata = apb_if_i.M_PRDATA;
    end else if (TO_EN && (m_age - 1) >= TO_CYC) begin
      m_act = 0; m_ack = 1'b1; m_err = 1'b1; m_rdata = '0;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("psel",    apb_if_i.M_PSELx,   m_act);
      chk("penable", apb_if_i.M_PENABLE, m_act && m_age >= 2);
      chk("paddr",   apb_if_i.M_PADDR,   m_act ? m_addr : '0);
      chk("pwrite",  apb_if_i.M_PWRITE,  m_act ? m_we : 1'b0);
      chk("pwdata",  apb_if_i.M_PWDATA,  m_act ? m_wdata : '0);
      chk("ack",     core_ack,           m_ack);
      chk("err",     core_err,           m_err);
      chk("rdata",   core_rdata,         m_rdata);
      chk("busy",    core_busy,          m_act);
      if (core_ack) n_ack++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request; PREADY rises on ACCESS cycle waits+1 (cycle 2+waits).
  task automatic run_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int waits, input logic [DW-1:0] prd,
                          output int ack_at, output int pen_cnt);
    int c0;
    ack_at = -1; pen_cnt = 0;
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
    c0 = cyc;
    for (int k = 1; k <= 6 + waits; k++) begin
      tick();
      core_req = 1'b0;
      apb_if_i.M_PREADY = (k == 2 + waits);
      apb_if_i.M_PRDATA = (k == 2 + waits) ? prd : 16'hBAD0;
      if (apb_if_i.M_PENABLE) pen_cnt++;
      if (core_ack && ack_at < 0) ack_at = cyc - c0;
    end
    apb_if_i.M_PREADY = 1'b0;
  endtask

  initial begin
    int ack_at, pen_cnt, c0, snap;
    logic err_at;
    apb_if_i.M_PREADY = 1'b0;
    apb_if_i.M_PRDATA = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_psel", apb_if_i.M_PSELx, 0);
    chk("rst_busy", core_busy, 0);
    chk("rst_rdata", core_rdata, 0);
    reset = 1'b0;
    cmp_en = 1'b1;
    tick();

    // Zero-wait write 0x00010 <- 0xBEEF
    core_req = 1; core_we = 1; core_addr = 20'h00010; core_wdata = 16'hBEEF;
    tick(); core_req = 0;                                    // cycle 1: SETUP
    chk("w0_setup_sel", apb_if_i.M_PSELx, 1);
    chk("w0_setup_en", apb_if_i.M_PENABLE, 0);
    chk("w0_paddr", apb_if_i.M_PADDR, 32'h00010);
    chk("w0_pwdata", apb_if_i.M_PWDATA, 32'hBEEF);
    chk("w0_pwrite", apb_if_i.M_PWRITE, 1);
    tick(); apb_if_i.M_PREADY = 1;                           // cycle 2: ACCESS
    chk("w0_access_en", apb_if_i.M_PENABLE, 1);
    tick(); apb_if_i.M_PREADY = 0;                           // cycle 3: ack
    chk("w0_ack", core_ack, 1);
    chk("w0_err", core_err, 0);
    chk("w0_rdata", core_rdata, 0);
    chk("w0_busy", core_busy, 0);
    tick();
    chk("w0_ack_one_cycle", core_ack, 0);

    // Read 0x00004 with 3 wait states
    run_xfer(1'b0, 20'h00004, 16'h0000, 3, 16'h1234, ack_at, pen_cnt);
    chk("r3_ack_cycle", ack_at, 6);
    chk("r3_penable_cycles", pen_cnt, 4);
    chk("r3_rdata", core_rdata, 32'h1234);

    // Back-to-back: read 0x1 then write 0x2 with core_req held high
    core_req = 1; core_we = 0; core_addr = 20'h1; core_wdata = 16'h0;
    tick(); core_we = 1; core_addr = 20'h2; core_wdata = 16'h5A5A;   // cycle 1
    tick(); apb_if_i.M_PREADY = 1; apb_if_i.M_PRDATA = 16'h0077;     // cycle 2
    tick(); apb_if_i.M_PREADY = 0;                                   // cycle 3
    chk("b2b_ack1", core_ack, 1);
    chk("b2b_rdata1", core_rdata, 32'h0077);
    tick(); core_req = 0;                                            // cycle 4
    chk("b2b_setup2_sel", apb_if_i.M_PSELx, 1);
    chk("b2b_setup2_en", apb_if_i.M_PENABLE, 0);
    chk("b2b_setup2_addr", apb_if_i.M_PADDR, 32'h2);
    chk("b2b_setup2_write", apb_if_i.M_PWRITE, 1);
    tick();                                                          // cycle 5, one wait
    tick(); apb_if_i.M_PREADY = 1;                                   // cycle 6
    tick(); apb_if_i.M_PREADY = 0;                                   // cycle 7
    chk("b2b_ack2", core_ack, 1);
    chk("b2b_rdata_kept", core_rdata, 32'h0077);
    tick();

    // Input stability during a 5-wait write; core inputs churn every cycle
    core_req = 1; core_we = 1; core_addr = 20'h00ABC; core_wdata = 16'h1111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      core_req = 0;
      core_we = 1'($urandom); core_addr = 20'($urandom); core_wdata = 16'($urandom);
      apb_if_i.M_PREADY = (k == 7);
      if (k <= 7) begin
        chk("stab_paddr", apb_if_i.M_PADDR, 32'h00ABC);
        chk("stab_pwdata", apb_if_i.M_PWDATA, 32'h1111);
        chk("stab_pwrite", apb_if_i.M_PWRITE, 1);
      end else begin
        chk("stab_ack", core_ack, 1);
      end
    end
    apb_if_i.M_PREADY = 0;
    tick();

    // Reset in the middle of ACCESS
    core_req = 1; core_we = 0; core_addr = 20'h00030;
    tick(); core_req = 0;              // SETUP
    tick(); reset = 1;                 // ACCESS, reset sampled at end of cycle
    snap = n_ack;
    tick(); reset = 0;
    chk("rst_mid_psel", apb_if_i.M_PSELx, 0);
    chk("rst_mid_penable", apb_if_i.M_PENABLE, 0);
    chk("rst_mid_busy", core_busy, 0);
    repeat (6) tick();
    chk("rst_mid_no_ack", n_ack, snap);

    // Prime core_rdata with a non-zero value before the stall test
    run_xfer(1'b0, 20'h00008, 16'h0, 0, 16'h4321, ack_at, pen_cnt);
    chk("prime_rdata", core_rdata, 32'h4321);

    // Slave never ready
    core_req = 1; core_we = 0; core_addr = 20'h00040;
    c0 = cyc; ack_at = -1; pen_cnt = 0; err_at = 0;
    for (int k = 1; k <= (TO_EN ? 10 : 100); k++) begin
      tick();
      core_req = 0;
      if (apb_if_i.M_PENABLE) pen_cnt++;
      if (core_ack && ack_at < 0) begin ack_at = cyc - c0; err_at = core_err; end
    end
    if (TO_EN) begin
      chk("to_ack_cycle", ack_at, 2 + TO_CYC);
      chk("to_err", err_at, 1);
      chk("to_penable_cycles", pen_cnt, TO_CYC);
      chk("to_rdata", core_rdata, 0);
    end else begin
      chk("stall_no_ack", ack_at, 32'hFFFF_FFFF);
      chk("stall_penable", apb_if_i.M_PENABLE, 1);
      chk("stall_busy", core_busy, 1);
    end
    reset = 1; tick(); reset = 0; tick();

    // Normal operation after recovery: read with one wait state
    run_xfer(1'b0, 20'h00050, 16'h0, 1, 16'h0F0F, ack_at, pen_cnt);
    chk("post_ack_cycle", ack_at, 4);
    chk("post_rdata", core_rdata, 32'h0F0F);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
